// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// the counter-width helper used to size the internal timers.
package pll_rst_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   // A counter must hold values up to n-1, but never drops below one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for bringing asynchronous levels into the clk domain.
// Cleared by the synchronous reset so downstream logic never sees a stale level.
module sync_ff_chain #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sync [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '{default: '0};
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the rPLL lock indication into debounced, staged, synchronous resets
// for the PLL output domain, and counts lock-loss events for debug.
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int LOCK_SYNC_STAGES = 2,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int RST_HOLD_CYC     = 16,
   parameter int NUM_STAGES       = 3,
   parameter int STAGE_GAP_CYC    = 8,
   parameter int LOSS_CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_lock,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  rst_done,
   output logic                  lock_synced,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
   output logic [STATE_W-1:0]    state_o
);

   localparam int SW = cnt_w(LOCK_STABLE_CYC);
   localparam int HW = cnt_w(RST_HOLD_CYC);
   localparam int GW = cnt_w(STAGE_GAP_CYC);
   localparam int IW = cnt_w(NUM_STAGES);

   localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD_CYC - 1);
   localparam logic [GW-1:0] GAP_RELOAD  = GW'(STAGE_GAP_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

   logic                  w_lock_synced;
   state_t                r_state,      w_state_nxt;
   logic [SW-1:0]         r_stable_cnt, w_stable_nxt;
   logic [HW-1:0]         r_hold_cnt,   w_hold_nxt;
   logic [GW-1:0]         r_gap_cnt,    w_gap_nxt;
   logic [IW-1:0]         r_stage_idx,  w_idx_nxt;
   logic [NUM_STAGES-1:0] r_stage_rst,  w_stage_nxt;
   logic [LOSS_CNT_W-1:0] r_loss_cnt,   w_loss_nxt;
   logic                  r_rst_done;

   sync_ff_chain #(
      .STAGES (LOCK_SYNC_STAGES),
      .WIDTH  (1)
   ) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .i_d (pll_lock),
      .o_q (w_lock_synced)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_stable_nxt = r_stable_cnt;
      w_hold_nxt   = r_hold_cnt;
      w_gap_nxt    = r_gap_cnt;
      w_idx_nxt    = r_stage_idx;
      w_stage_nxt  = r_stage_rst;
      w_loss_nxt   = r_loss_cnt;

      // Losing lock after the debounce window throws everything back to the start.
      if ((r_state != WAIT_LOCK) && !w_lock_synced) begin
         w_state_nxt  = WAIT_LOCK;
         w_stable_nxt = '0;
         w_hold_nxt   = '0;
         w_gap_nxt    = '0;
         w_idx_nxt    = '0;
         w_stage_nxt  = '1;
         if (r_loss_cnt != '1) begin
            w_loss_nxt = r_loss_cnt + 1'b1;
         end
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               if (!w_lock_synced) begin
                  w_stable_nxt = '0;
               end else if (r_stable_cnt == STABLE_LAST) begin
                  w_state_nxt  = HOLD;
                  w_stable_nxt = '0;
                  w_hold_nxt   = '0;
               end else begin
                  w_stable_nxt = r_stable_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  w_state_nxt = RELEASE;
                  w_hold_nxt  = '0;
                  w_idx_nxt   = '0;
                  w_gap_nxt   = '0;
               end else begin
                  w_hold_nxt = r_hold_cnt + 1'b1;
               end
            end
            RELEASE: begin
               // gap_cnt is a down-counter; zero marks a release cycle.
               if (r_gap_cnt != '0) begin
                  w_gap_nxt = r_gap_cnt - 1'b1;
               end else begin
                  w_stage_nxt[r_stage_idx] = 1'b0;
                  if (r_stage_idx == IDX_LAST) begin
                     w_state_nxt = RUN;
                  end else begin
                     w_idx_nxt = r_stage_idx + 1'b1;
                     w_gap_nxt = GAP_RELOAD;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= WAIT_LOCK;
         r_stable_cnt <= '0;
         r_hold_cnt   <= '0;
         r_gap_cnt    <= '0;
         r_stage_idx  <= '0;
         r_stage_rst  <= '1;
         r_loss_cnt   <= '0;
         r_rst_done   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_stable_cnt <= w_stable_nxt;
         r_hold_cnt   <= w_hold_nxt;
         r_gap_cnt    <= w_gap_nxt;
         r_stage_idx  <= w_idx_nxt;
         r_stage_rst  <= w_stage_nxt;
         r_loss_cnt   <= w_loss_nxt;
         r_rst_done   <= (w_state_nxt == RUN);
      end
   end

   assign stage_rst     = r_stage_rst;
   assign rst_done      = r_rst_done;
   assign lock_synced   = w_lock_synced;
   assign lock_loss_cnt = r_loss_cnt;
   assign state_o       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: expected output events are queued with their cycle when
// stimulus is applied and compared at the falling edge of that cycle.
module tb_pll_reset_sequencer;

   localparam int LSC   = 1024;
   localparam int HOLDC = 16;
   localparam int A_NS  = 3;
   localparam int A_GAP = 8;
   localparam int B_NS  = 1;
   localparam int B_GAP = 1;

   localparam int K_STG  = 0;
   localparam int K_DONE = 1;
   localparam int K_ST   = 2;
   localparam int K_LOSS = 3;
   localparam int K_SYNC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_a, lock_a, done_a, sync_a;
   logic [2:0] stg_a;
   logic [7:0] loss_a;
   logic [1:0] st_a;
   logic       rst_b, lock_b, done_b, sync_b;
   logic [0:0] stg_b;
   logic [1:0] loss_b;
   logic [1:0] st_b;

   pll_reset_sequencer u_dut_a (
      .clk           (clk),
      .rst           (rst_a),
      .pll_lock      (lock_a),
      .stage_rst     (stg_a),
      .rst_done      (done_a),
      .lock_synced   (sync_a),
      .lock_loss_cnt (loss_a),
      .state_o       (st_a)
   );

   pll_reset_sequencer #(
      .NUM_STAGES    (1),
      .STAGE_GAP_CYC (1),
      .LOSS_CNT_W    (2)
   ) u_dut_b (
      .clk           (clk),
      .rst           (rst_b),
      .pll_lock      (lock_b),
      .stage_rst     (stg_b),
      .rst_done      (done_b),
      .lock_synced   (sync_b),
      .lock_loss_cnt (loss_b),
      .state_o       (st_b)
   );

   typedef struct {
      int          dut;
      int          kind;
      int          at;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] observe(input int dut, input int kind);
      logic [31:0] v;
      v = '0;
      case (kind)
         K_STG:  v = (dut == 0) ? 32'(stg_a)  : 32'(stg_b);
         K_DONE: v = (dut == 0) ? 32'(done_a) : 32'(done_b);
         K_ST:   v = (dut == 0) ? 32'(st_a)   : 32'(st_b);
         K_LOSS: v = (dut == 0) ? 32'(loss_a) : 32'(loss_b);
         K_SYNC: v = (dut == 0) ? 32'(sync_a) : 32'(sync_b);
         default: v = 'x;
      endcase
      return v;
   endfunction

   task automatic push(input int dut, input int kind, input int at, input logic [31:0] exp,
                       input string tag);
      exp_t e;
      int   i;
      e.dut  = dut;
      e.kind = kind;
      e.at   = at;
      e.exp  = exp;
      e.tag  = (dut == 0) ? {"A_", tag} : {"B_", tag};
      i = 0;
      while (i < sb.size() && sb[i].at <= at) i++;
      sb.insert(i, e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         if (e.at < cyc) check_val({e.tag, "_missed"}, 32'(cyc), 32'(e.at));
         else            check_val(e.tag, observe(e.dut, e.kind), e.exp);
      end
   end

   // Advance to cycle target, then land at a random point inside that cycle.
   task automatic goto(input int target);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < target);
      #($urandom_range(0, 7));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_val("drain", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   // Expected timeline once lock_synced first reads high after edge e0.
   task automatic push_release(input int dut, input int e0, input int loss);
      int          ns, gap, t0, tk, tl;
      logic [31:0] all;
      ns  = (dut == 0) ? A_NS : B_NS;
      gap = (dut == 0) ? A_GAP : B_GAP;
      all = (32'd1 << ns) - 1;
      t0  = e0 + LSC + HOLDC + 1;
      tl  = t0 + (ns - 1) * gap;
      push(dut, K_SYNC, e0 - 1, 0, "sync_lo");
      push(dut, K_SYNC, e0, 1, "sync_hi");
      push(dut, K_ST, e0 + LSC - 1, 0, "wait_end");
      push(dut, K_ST, e0 + LSC, 1, "hold_entry");
      push(dut, K_ST, t0, (ns > 1) ? 2 : 3, "release_entry");
      for (int k = 0; k < ns; k++) begin
         tk = t0 + k * gap;
         push(dut, K_STG, tk - 1, (all << k) & all, "stage_pre");
         push(dut, K_STG, tk, (all << (k + 1)) & all, "stage_clr");
      end
      push(dut, K_DONE, tl - 1, 0, "done_pre");
      push(dut, K_DONE, tl, 1, "done");
      push(dut, K_ST, tl, 3, "run");
      push(dut, K_LOSS, tl, loss, "loss_run");
   endtask

   // pll_lock dropped during cycle c while running.
   task automatic push_loss(input int dut, input int c, input int loss);
      logic [31:0] all;
      all = (32'd1 << ((dut == 0) ? A_NS : B_NS)) - 1;
      push(dut, K_DONE, c + 2, 1, "done_before_loss");
      push(dut, K_STG, c + 3, all, "loss_stage");
      push(dut, K_DONE, c + 3, 0, "loss_done");
      push(dut, K_ST, c + 3, 0, "loss_state");
      push(dut, K_LOSS, c + 3, loss, "loss_cnt");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, e0;
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      lock_a = 1'b0;
      lock_b = 1'b0;

      goto(2);
      for (int d = 0; d < 2; d++) begin
         push(d, K_STG, 3, (d == 0) ? 32'h7 : 32'h1, "rst_stage");
         push(d, K_DONE, 3, 0, "rst_done");
         push(d, K_ST, 3, 0, "rst_state");
         push(d, K_LOSS, 3, 0, "rst_loss");
         push(d, K_SYNC, 3, 0, "rst_sync");
      end

      // Power-up
      goto(4);
      rst_a  = 1'b0;
      lock_a = 1'b1;
      push_release(0, cyc + 2, 0);
      drain(1200);

      // Lock loss in RUN, then relock
      goto(cyc + 20);
      lock_a = 1'b0;
      push_loss(0, cyc, 1);
      goto(cyc + 10);
      lock_a = 1'b1;
      push_release(0, cyc + 2, 1);
      drain(1200);

      // Loss while releasing, after bit 0 has cleared
      goto(cyc + 20);
      lock_a = 1'b0;
      push_loss(0, cyc, 2);
      goto(cyc + 10);
      lock_a = 1'b1;
      e0 = cyc + 2;
      push(0, K_STG, e0 + 1040, 32'h7, "mid_pre");
      push(0, K_STG, e0 + 1041, 32'h6, "mid_bit0");
      goto(e0 + 1042);
      lock_a = 1'b0;
      c = cyc;
      push(0, K_STG, c + 2, 32'h6, "mid_before_loss");
      push(0, K_ST, c + 2, 2, "mid_state_release");
      push(0, K_STG, c + 3, 32'h7, "mid_loss_stage");
      push(0, K_ST, c + 3, 0, "mid_loss_state");
      push(0, K_DONE, c + 3, 0, "mid_loss_done");
      push(0, K_LOSS, c + 3, 3, "mid_loss_cnt");
      drain(50);

      // Single-cycle glitch at stable count 500 restarts the window
      goto(cyc + 10);
      lock_a = 1'b1;
      e0 = cyc + 2;
      push(0, K_ST, e0 + LSC, 0, "glitch_no_hold");
      push(0, K_STG, e0 + 1041, 32'h7, "glitch_no_release");
      goto(e0 + 498);
      lock_a = 1'b0;
      goto(cyc + 1);
      lock_a = 1'b1;
      push_release(0, e0 + 501, 3);
      drain(1700);

      // rst and lock loss seen in the same cycle while running
      goto(cyc + 20);
      lock_a = 1'b0;
      c = cyc;
      push(0, K_DONE, c + 2, 1, "rstloss_run");
      push(0, K_ST, c + 3, 0, "rstloss_state");
      push(0, K_LOSS, c + 3, 0, "rstloss_cnt");
      push(0, K_STG, c + 3, 32'h7, "rstloss_stage");
      push(0, K_DONE, c + 3, 0, "rstloss_done");
      push(0, K_LOSS, c + 6, 0, "rstloss_cnt_after");
      push(0, K_ST, c + 6, 0, "rstloss_state_after");
      goto(c + 2);
      rst_a = 1'b1;
      goto(c + 3);
      rst_a = 1'b0;
      drain(20);

      // Single stage, gap 1, 2-bit saturating loss counter
      goto(cyc + 5);
      rst_b  = 1'b0;
      lock_b = 1'b1;
      push_release(1, cyc + 2, 0);
      drain(1200);
      for (int k = 1; k <= 5; k++) begin
         goto(cyc + 20);
         lock_b = 1'b0;
         push_loss(1, cyc, (k > 3) ? 3 : k);
         goto(cyc + 10);
         lock_b = 1'b1;
         push_release(1, cyc + 2, (k > 3) ? 3 : k);
         drain(1200);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
